// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and helpers for the VGA timing generator.
//   - default 640x480@60 timing (25 MHz pixel clock from a 100 MHz clk)
//   - line_total(): sum of the four segments of a line or frame
//   - clog2(): counter width for a given number of states (minimum 1)
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_RGB_W    = 12;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Width needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_sync_gen_tick.sv
// -----------------------------------------------------------------------------
// vga_tick_gen
// Pixel clock-enable divider. Produces a one-clk pix_tick every CLK_DIV clks
// while en is high; dropping en clears the divider on the next clk.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   en       in   run enable
//   pix_tick out  one-clk pixel strobe (held high when CLK_DIV = 1)
// -----------------------------------------------------------------------------
module vga_tick_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pix_tick
);

  localparam int DW = clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick_q;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // tick_q mirrors (div_cnt == CLK_DIV-1) but as a register, so the strobe
  // is glitch-free and reads 0 while reset is held, even for CLK_DIV = 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick_q  <= (div_nxt == DIV_LAST);
    end
  end

  // Gating with en keeps the counters from advancing in the clk where en falls.
  assign pix_tick = tick_q & en;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Parametrised VGA timing generator with pixel coordinates, line/frame strobes
// and registered, mutually aligned hsync/vsync/vga_rgb outputs.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   en          in   run enable; low clears the raster to (0,0)
//   rgb_in      in   colour for pixel (pix_x, pix_y), sampled on pix_tick
//   pix_tick    out  one-clk pixel-enable strobe
//   pix_x       out  current horizontal count
//   pix_y       out  current vertical count
//   video_on    out  (pix_x, pix_y) lies in the active area
//   line_start  out  one-clk pulse in the first clk of pixel x = 0
//   frame_start out  one-clk pulse in the first clk of pixel (0,0)
//   hsync       out  horizontal sync, active level HS_POL
//   vsync       out  vertical sync, active level VS_POL
//   vga_rgb     out  colour to pins, zero outside the active area
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter  int H_ACTIVE = DEF_H_ACTIVE,
  parameter  int H_FP     = DEF_H_FP,
  parameter  int H_SYNC   = DEF_H_SYNC,
  parameter  int H_BP     = DEF_H_BP,
  parameter  int V_ACTIVE = DEF_V_ACTIVE,
  parameter  int V_FP     = DEF_V_FP,
  parameter  int V_SYNC   = DEF_V_SYNC,
  parameter  int V_BP     = DEF_V_BP,
  parameter  int CLK_DIV  = DEF_CLK_DIV,
  parameter  int HS_POL   = 0,
  parameter  int VS_POL   = 0,
  parameter  int RGB_W    = DEF_RGB_W,
  localparam int H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW       = clog2(H_TOTAL),
  localparam int YW       = clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_tick,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [31:0]   H_ACT    = H_ACTIVE;
  localparam logic [31:0]   V_ACT    = V_ACTIVE;
  localparam logic [31:0]   HS_START = H_ACTIVE + H_FP;
  localparam logic [31:0]   HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [31:0]   VS_START = V_ACTIVE + V_FP;
  localparam logic [31:0]   VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic [31:0]   hx;
  logic [31:0]   vy;
  logic          h_wrap;
  logic          v_wrap;
  logic          in_hs;
  logic          in_vs;
  logic          run_q;

  vga_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pix_tick (pix_tick)
  );

  assign hx       = 32'(h_cnt);
  assign vy       = 32'(v_cnt);
  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign in_hs    = (hx >= HS_START) && (hx < HS_END);
  assign in_vs    = (vy >= VS_START) && (vy < VS_END);
  assign video_on = (hx < H_ACT) && (vy < V_ACT);
  assign pix_x    = h_cnt;
  assign pix_y    = v_cnt;

  // run_q low means the raster has just (re)started at (0,0); the first
  // enabled clk then raises line_start/frame_start for that pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      run_q       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      vga_rgb     <= '0;
    end else if (!en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      run_q       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      vga_rgb     <= '0;
    end else begin
      run_q       <= 1'b1;
      line_start  <= !run_q || (pix_tick && h_wrap);
      frame_start <= !run_q || (pix_tick && h_wrap && v_wrap);
      if (pix_tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        // Decoded from the pixel just finished, so these trail pix_x/pix_y
        // by one pixel period and stay aligned with each other.
        hsync   <= in_hs ? HS_ON : ~HS_ON;
        vsync   <= in_vs ? VS_ON : ~VS_ON;
        vga_rgb <= video_on ? rgb_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int DIV = 2, HPOL = 1, VPOL = 0, RW = 12;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 8

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [RW-1:0] rgb_in = '0;
  logic          pix_tick;
  logic [3:0]    pix_x;
  logic [2:0]    pix_y;
  logic          video_on, line_start, frame_start, hsync, vsync;
  logic [RW-1:0] vga_rgb;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .HS_POL(HPOL), .VS_POL(VPOL), .RGB_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sync_lvl(input bit active, input int pol);
    return active ? (pol != 0) : (pol == 0);
  endfunction

  // Model: m_e = enabled clk edges since the raster restarted, m_t = pixel
  // ticks since then. Coordinates follow from m_t by division.
  int            m_e, m_t;
  logic          m_ls, m_fs, m_hs, m_vs;
  logic [RW-1:0] m_rgb;

  always @(posedge clk or negedge rst) begin : model
    bit tick, first, wrap;
    int h, v;
    if (!rst || !en) begin
      m_e = 0; m_t = 0; m_ls = 0; m_fs = 0;
      m_hs = sync_lvl(0, HPOL); m_vs = sync_lvl(0, VPOL); m_rgb = '0;
    end else begin
      tick  = (m_e >= 1) && (m_e % DIV == DIV - 1);
      first = (m_e == 0);
      if (tick) begin
        h = m_t % HT;
        v = (m_t / HT) % VT;
        m_hs  = sync_lvl(h >= HA + HF && h < HA + HF + HS, HPOL);
        m_vs  = sync_lvl(v >= VA + VF && v < VA + VF + VS, VPOL);
        m_rgb = (h < HA && v < VA) ? rgb_in : '0;
        m_t++;
      end
      m_e++;
      wrap = tick && (m_t % HT == 0);
      m_ls = first || wrap;
      m_fs = first || (wrap && ((m_t / HT) % VT == 0));
    end
  end

  always @(negedge clk) begin : compare
    int h, v;
    if (chk_on) begin
      h = m_t % HT;
      v = (m_t / HT) % VT;
      check("pix_tick", int'(pix_tick), int'(en && m_e >= 1 && m_e % DIV == DIV - 1));
      check("pix_x", int'(pix_x), h);
      check("pix_y", int'(pix_y), v);
      check("video_on", int'(video_on), int'(h < HA && v < VA));
      check("line_start", int'(line_start), int'(m_ls));
      check("frame_start", int'(frame_start), int'(m_fs));
      check("hsync", int'(hsync), int'(m_hs));
      check("vsync", int'(vsync), int'(m_vs));
      check("vga_rgb", int'(vga_rgb), int'(m_rgb));
    end
  end

  initial begin
    int  n;
    bit  hit;

    #2 rst = 1'b0;
    chk_on = 1;
    en = 1'b1;
    #1;
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_hsync", int'(hsync), 0);
    check("rst_vsync", int'(vsync), 1);
    check("rst_rgb", int'(vga_rgb), 0);
    check("rst_pix_tick", int'(pix_tick), 0);
    check("rst_frame_start", int'(frame_start), 0);

    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    // counters first advance on the CLK_DIV-th edge after release
    n = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); n++; #1;
      if (pix_x == 4'd1) hit = 1;
    end
    check("first_advance_edges", n, DIV);

    // line and frame spacing
    for (int k = 0; k < 2; k++) begin
      n = 0; hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        @(negedge clk); n++;
        if (line_start) hit = 1;
      end
      if (k == 1) check("line_period", n, 30);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0; hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        @(negedge clk); n++;
        if (frame_start) hit = 1;
      end
      if (k == 1) check("frame_period", n, 240);
    end

    // hsync active-high width (3 pixels), vsync active-low width (2 lines)
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin @(negedge clk); if (hsync) hit = 1; end
    n = hit ? 1 : 0;
    for (int i = 0; i < 1000 && hit; i++) begin @(negedge clk); if (hsync) n++; else hit = 0; end
    check("hsync_width", n, 6);
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin @(negedge clk); if (!vsync) hit = 1; end
    n = hit ? 1 : 0;
    for (int i = 0; i < 1000 && hit; i++) begin @(negedge clk); if (!vsync) n++; else hit = 0; end
    check("vsync_width", n, 60);

    // constant colour: 32 active pixels x 2 clk per frame
    @(posedge clk); #1 rgb_in = 12'hF0A;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin @(negedge clk); if (frame_start) hit = 1; end
    n = (vga_rgb == 12'hF0A) ? 1 : 0;
    for (int i = 1; i < 240; i++) begin
      @(negedge clk);
      if (vga_rgb == 12'hF0A) n++;
    end
    check("rgb_active_clks", n, 64);

    // en dropped at (5,2), then raised again
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (pix_x == 4'd5 && pix_y == 3'd2) hit = 1;
    end
    check("reach_5_2", int'(hit), 1);
    @(posedge clk); #1 en = 1'b0;
    repeat (3) @(negedge clk);
    check("en0_hsync", int'(hsync), 0);
    check("en0_vsync", int'(vsync), 1);
    check("en0_rgb", int'(vga_rgb), 0);
    check("en0_pix_y", int'(pix_y), 0);
    @(posedge clk); #1 en = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin @(negedge clk); if (frame_start) hit = 1; end
    check("reen_frame_start", int'(hit), 1);
    check("reen_pix_x", int'(pix_x), 0);
    check("reen_pix_y", int'(pix_y), 0);

    // async reset pulse mid-line, while an active pixel is shown
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (pix_x == 4'd3 && pix_y == 3'd1) hit = 1;
    end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("arst_pix_x", int'(pix_x), 0);
    check("arst_pix_y", int'(pix_y), 0);
    check("arst_hsync", int'(hsync), 0);
    check("arst_vsync", int'(vsync), 1);
    check("arst_rgb", int'(vga_rgb), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    n = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); n++; #1;
      if (pix_x == 4'd1) hit = 1;
    end
    check("restart_edges", n, DIV);

    // random colour every clk with occasional enable drops
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rgb_in = RW'($urandom);
      en = ($urandom_range(0, 199) < 3) ? 1'b0 : 1'b1;
    end
    @(posedge clk); #1 en = 1'b1;
    repeat (600) @(posedge clk);

    @(negedge clk);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Parametrised VGA timing generator. Successor to the fixed 640x480 vga_sync block.
- Timing, sync polarity, pixel-clock division and colour width are all parameters.
- Adds an enable input, pixel coordinate outputs, and line/frame start strobes, so a downstream pixel generator can drive rgb_in.
- Sits between the board clock and the VGA connector pins, below the game/pattern logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1); 100 MHz / 4 = 25 MHz
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync
- RGB_W, 12, colour bus width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  run enable
- rgb_in  in  RGB_W  colour for pixel (pix_x, pix_y)
- pix_tick  out  1  one-clk pixel-enable strobe
- pix_x  out  clog2(H_TOTAL)  current horizontal count
- pix_y  out  clog2(V_TOTAL)  current vertical count
- video_on  out  1  (pix_x, pix_y) is in the active area
- line_start  out  1  one-clk pulse at h_cnt wrap to 0
- frame_start  out  1  one-clk pulse at h_cnt = 0 and v_cnt = 0
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- vga_rgb  out  RGB_W  colour to DAC/pins, blanked outside the active area

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
- Reset (rst = 0, async):
  - div_cnt, h_cnt, v_cnt = 0
  - pix_tick, line_start, frame_start = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - vga_rgb = 0
- Reset release is synchronous to clk; the first pix_tick occurs CLK_DIV cycles after release.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en = 1.
  - pix_tick = 1 for the single clk where div_cnt = CLK_DIV-1.
  - CLK_DIV = 1 gives pix_tick held at 1.
- Counters (advance only on pix_tick):
  - h_cnt increments and wraps at H_TOTAL-1 to 0.
  - On the h wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
- pix_x = h_cnt and pix_y = v_cnt, direct from the registers.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), combinational decode of the counters.
- line_start is registered, high for the one clk after h_cnt becomes 0. frame_start is the same, additionally qualified by v_cnt = 0.
- Sync windows:
  - hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Output stage:
  - hsync, vsync and vga_rgb are registered on pix_tick from the decode of the current counters.
  - They therefore lag pix_x/pix_y by exactly one pixel period and stay mutually aligned.
  - vga_rgb = video_on ? rgb_in : 0.
- en = 0:
  - div_cnt, h_cnt and v_cnt are synchronously cleared to 0 on the next clk.
  - pix_tick, line_start and frame_start are 0.
  - hsync and vsync go inactive; vga_rgb = 0.
  - On re-enable the frame restarts from (0,0), with frame_start asserted for the first pixel.
- rgb_in is sampled only when pix_tick = 1; changes between ticks have no effect.
- rst asserted mid-frame returns all state to the reset values immediately.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL computation helpers
  - a clog2 function for the counter widths
- One sub-module: vga_tick_gen, the CLK_DIV clock-enable divider with en and async active-low rst. Output: pix_tick.

Test Plan:
- Defaults, 10 ns clk, en = 1:
  - pix_tick period is 40 ns.
  - hsync period is 3200 clk; hsync low for 384 clk.
  - vsync period is 1,680,000 clk; vsync low for 6400 clk (2 lines).
- Small timing (H 8/2/3/2, V 4/1/2/1, CLK_DIV = 2):
  - h_cnt wraps 14 -> 0 and v_cnt wraps 7 -> 0.
  - line_start occurs every 30 clk; frame_start every 240 clk.
- rgb_in = 12'hF0A held constant:
  - vga_rgb = F0A for exactly H_ACTIVE pixels per active line.
  - vga_rgb = 0 during porches and V blanking.
  - vga_rgb lags video_on by one pixel period.
- HS_POL = 1, VS_POL = 1: sync pulses are active-high, with the same widths and positions as the default case.
- en dropped at (h = 300, v = 200) then raised:
  - sync goes inactive and vga_rgb = 0 while en = 0.
  - After raising en, frame_start occurs with pix_x = 0, pix_y = 0.
- rst pulsed low mid-line, asynchronously between clk edges: all outputs show their reset values without waiting for a clk edge, and counting restarts CLK_DIV cycles after release.
